// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int DEF_LINE_BYTES = 16;
    localparam int DEF_NUM_SETS   = 16;
    localparam int DEF_OFF_W      = $clog2(DEF_LINE_BYTES);
    localparam int DEF_IDX_W      = $clog2(DEF_NUM_SETS);
    localparam int DEF_TAG_W      = 32 - DEF_OFF_W - DEF_IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    // Helpers return 32-bit results; callers size-cast to the field width.
    function automatic logic [31:0] addr_index(input logic [31:0] a, input int off_w, input int idx_w);
        return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w, input int idx_w);
        return a >> (off_w + idx_w);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] a, input int off_w);
        return (a >> 2) & ((32'd1 << (off_w - 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read by index, synchronous writes.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int NUM_SETS   = DEF_NUM_SETS
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [$clog2(NUM_SETS)-1:0]                            index,
    output logic                                                   rd_valid,
    output logic                                                   rd_dirty,
    output logic [32-$clog2(LINE_BYTES)-$clog2(NUM_SETS)-1:0]      rd_tag,
    output logic [8*LINE_BYTES-1:0]                                rd_data,
    input  logic                                                   word_we,
    input  logic [$clog2(LINE_BYTES)-3:0]                          word_sel,
    input  logic [31:0]                                            word_data,
    input  logic                                                   fill_we,
    input  logic [32-$clog2(LINE_BYTES)-$clog2(NUM_SETS)-1:0]      fill_tag,
    input  logic [8*LINE_BYTES-1:0]                                fill_data,
    input  logic                                                   dirty_clr
);

    localparam int TAG_W     = 32 - $clog2(LINE_BYTES) - $clog2(NUM_SETS);
    localparam int LINE_BITS = 8 * LINE_BYTES;

    logic [NUM_SETS-1:0]  valid;
    logic [NUM_SETS-1:0]  dirty;
    logic [TAG_W-1:0]     tags [NUM_SETS];
    logic [LINE_BITS-1:0] data [NUM_SETS];

    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_tag   = tags[index];
    assign rd_data  = data[index];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_we) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (word_we) begin
            dirty[index] <= 1'b1;
        end else if (dirty_clr) begin
            dirty[index] <= 1'b0;
        end
    end

    // Tag and data need no reset: they are qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tags[index] <= fill_tag;
            data[index] <= fill_data;
        end else if (word_we) begin
            data[index][{word_sel, 5'b0} +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back/write-allocate data cache: FSM, counters, hit compare, memory request mux.
module dcache_direct_mapped
    import dcache_pkg::*;
#(
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int NUM_SETS   = DEF_NUM_SETS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      is_input_valid,
    input  logic [31:0]               addr,
    input  logic                      mem_rw,
    input  logic [31:0]               din,
    output logic                      is_ready,
    output logic                      is_output_valid,
    output logic [31:0]               dout,
    output logic                      is_hit,
    output logic                      mem_req_valid,
    output logic                      mem_req_write,
    output logic [31:0]               mem_req_addr,
    output logic [8*LINE_BYTES-1:0]   mem_req_wdata,
    input  logic                      mem_req_ready,
    input  logic                      mem_resp_valid,
    input  logic [8*LINE_BYTES-1:0]   mem_resp_rdata,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
);

    localparam int OFF_W     = $clog2(LINE_BYTES);
    localparam int IDX_W     = $clog2(NUM_SETS);
    localparam int TAG_W     = 32 - OFF_W - IDX_W;
    localparam int WSEL_W    = OFF_W - 2;
    localparam int LINE_BITS = 8 * LINE_BYTES;

    state_t              state, state_nxt;
    logic                replay;
    logic                req_sent;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    req_tag;
    logic [WSEL_W-1:0]   wsel;

    logic                rd_valid, rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic                line_hit;
    logic                word_we, fill_we, dirty_clr;

    assign idx     = IDX_W'(addr_index(addr, OFF_W, IDX_W));
    assign req_tag = TAG_W'(addr_tag(addr, OFF_W, IDX_W));
    assign wsel    = WSEL_W'(addr_word(addr, OFF_W));

    dcache_array #(
        .LINE_BYTES (LINE_BYTES),
        .NUM_SETS   (NUM_SETS)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .index     (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .word_we   (word_we),
        .word_sel  (wsel),
        .word_data (din),
        .fill_we   (fill_we),
        .fill_tag  (req_tag),
        .fill_data (mem_resp_rdata),
        .dirty_clr (dirty_clr)
    );

    assign line_hit = rd_valid && (rd_tag == req_tag);

    always_comb begin
        state_nxt       = state;
        is_ready        = (state == IDLE);
        is_hit          = is_ready && is_input_valid && line_hit;
        is_output_valid = is_hit;
        dout            = (is_hit && !mem_rw) ? rd_data[{wsel, 5'b0} +: 32] : 32'd0;
        word_we         = is_hit && mem_rw;
        fill_we         = 1'b0;
        dirty_clr       = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_addr    = {req_tag, idx, {OFF_W{1'b0}}};
        mem_req_wdata   = '0;
        case (state)
            IDLE: begin
                if (is_input_valid && !line_hit)
                    state_nxt = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {rd_tag, idx, {OFF_W{1'b0}}};
                mem_req_wdata = rd_data;
                if (mem_req_ready) begin
                    dirty_clr = 1'b1;
                    state_nxt = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_req_valid = !req_sent;
                // A response counts only once the fetch has been accepted (or in that same cycle).
                if (mem_resp_valid && (req_sent || mem_req_ready)) begin
                    fill_we   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req_sent <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != ALLOCATE || fill_we)
                req_sent <= 1'b0;
            else if (mem_req_valid && mem_req_ready)
                req_sent <= 1'b1;
        end
    end

    // The replayed access after a fill was already counted as a miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
            replay     <= 1'b0;
        end else if (is_hit) begin
            if (!replay)
                hit_count <= hit_count + 32'd1;
            replay <= 1'b0;
        end else if (is_ready && is_input_valid) begin
            miss_count <= miss_count + 32'd1;
            replay     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed self-checking bench for dcache_direct_mapped (16-byte lines, 16 sets).
module tb_dcache_direct_mapped;

    localparam int LB    = 16;
    localparam int NS    = 16;
    localparam int LBITS = 8 * LB;

    logic             clk = 1'b0;
    logic             reset;
    logic             is_input_valid;
    logic [31:0]      addr;
    logic             mem_rw;
    logic [31:0]      din;
    logic             is_ready, is_output_valid, is_hit;
    logic [31:0]      dout;
    logic             mem_req_valid, mem_req_write;
    logic [31:0]      mem_req_addr;
    logic [LBITS-1:0] mem_req_wdata;
    logic             mem_req_ready, mem_resp_valid;
    logic [LBITS-1:0] mem_resp_rdata;
    logic [31:0]      hit_count, miss_count;

    int n_cmp = 0;
    int n_err = 0;
    int fetch_acc = 0;

    dcache_direct_mapped #(.LINE_BYTES(LB), .NUM_SETS(NS)) dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
        .mem_rw(mem_rw), .din(din), .is_ready(is_ready), .is_output_valid(is_output_valid),
        .dout(dout), .is_hit(is_hit), .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Fetch handshakes seen at each edge (pre-edge values).
    always @(posedge clk)
        if (!reset && mem_req_valid && mem_req_ready && !mem_req_write)
            fetch_acc <= fetch_acc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [31:0] a, input logic [31:0] d);
        is_input_valid = v; mem_rw = rw; addr = a; din = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; drive(1'b0, 1'b0, 32'h0, 32'h0);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (is_ready !== 1'b1)        begin n_err++; $display("FAIL reset_ready: got %b want 1", is_ready); end
        n_cmp++; if (is_output_valid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %b want 0", is_output_valid); end
        n_cmp++; if (is_hit !== 1'b0)          begin n_err++; $display("FAIL reset_hit: got %b want 0", is_hit); end
        n_cmp++; if (mem_req_valid !== 1'b0)   begin n_err++; $display("FAIL reset_reqv: got %b want 0", mem_req_valid); end
        n_cmp++; if (dout !== 32'h0)           begin n_err++; $display("FAIL reset_dout: got %h want 0", dout); end
        n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
            begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
    endtask

    task automatic test_read_miss();
        int acc0;
        acc0 = fetch_acc;
        tick();
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        #1;
        n_cmp++; if (is_hit !== 1'b0 || is_output_valid !== 1'b0)
            begin n_err++; $display("FAIL miss_nohit: got hit=%b ov=%b want 0/0", is_hit, is_output_valid); end
        tick();
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h100)
            begin n_err++; $display("FAIL miss_fetch_req: got v=%b w=%b a=%h want 1/0/00000100", mem_req_valid, mem_req_write, mem_req_addr); end
        n_cmp++; if (is_ready !== 1'b0) begin n_err++; $display("FAIL miss_busy: got %b want 0", is_ready); end
        n_cmp++; if (miss_count !== 32'd1) begin n_err++; $display("FAIL miss_count1: got %0d want 1", miss_count); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL miss_req_drop: got %b want 0", mem_req_valid); end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_cmp++; if (is_output_valid !== 1'b1 || dout !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL miss_replay: got ov=%b dout=%h want 1/deadbeef", is_output_valid, dout); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd1)
            begin n_err++; $display("FAIL miss_counts: got %0d/%0d want 0/1", hit_count, miss_count); end
        n_cmp++; if (fetch_acc - acc0 !== 1) begin n_err++; $display("FAIL miss_one_fetch: got %0d want 1", fetch_acc - acc0); end
    endtask

    task automatic test_store_load_hit();
        drive(1'b1, 1'b1, 32'h104, 32'h12345678);
        #1;
        n_cmp++; if (is_output_valid !== 1'b1 || is_hit !== 1'b1)
            begin n_err++; $display("FAIL store_hit: got ov=%b hit=%b want 1/1", is_output_valid, is_hit); end
        tick();
        drive(1'b1, 1'b0, 32'h104, 32'h0);
        #1;
        n_cmp++; if (is_output_valid !== 1'b1 || dout !== 32'h12345678)
            begin n_err++; $display("FAIL load_after_store: got ov=%b dout=%h want 1/12345678", is_output_valid, dout); end
        tick();
        drive(1'b1, 1'b0, 32'h10C, 32'h0);
        #1;
        n_cmp++; if (dout !== 32'h33333333) begin n_err++; $display("FAIL load_last_word: got %h want 33333333", dout); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_cmp++; if (hit_count !== 32'd3 || miss_count !== 32'd1)
            begin n_err++; $display("FAIL hit_counts: got %0d/%0d want 3/1", hit_count, miss_count); end
    endtask

    task automatic test_dirty_evict_backpressure();
        logic [31:0]      a0;
        logic [LBITS-1:0] w0;
        int               acc0;
        int               bad;
        acc0 = fetch_acc;
        bad  = 0;
        drive(1'b1, 1'b0, 32'h204, 32'h0);
        tick();
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_addr !== 32'h100)
            begin n_err++; $display("FAIL wb_req: got v=%b w=%b a=%h want 1/1/00000100", mem_req_valid, mem_req_write, mem_req_addr); end
        n_cmp++; if (mem_req_wdata !== {32'h33333333, 32'h22222222, 32'h12345678, 32'hDEADBEEF})
            begin n_err++; $display("FAIL wb_data: got %h want 33333333222222221234567 8deadbeef", mem_req_wdata); end
        n_cmp++; if (miss_count !== 32'd2) begin n_err++; $display("FAIL wb_miss_count: got %0d want 2", miss_count); end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h200)
            begin n_err++; $display("FAIL alloc_req: got v=%b w=%b a=%h want 1/0/00000200", mem_req_valid, mem_req_write, mem_req_addr); end
        a0 = mem_req_addr;
        w0 = mem_req_wdata;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== a0 ||
                mem_req_wdata !== w0 || is_ready !== 1'b0)
                bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL backpressure_stable: got %0d unstable cycles want 0", bad); end
        // Accept and respond in the same cycle.
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        n_cmp++; if (is_output_valid !== 1'b1 || dout !== 32'h66666666)
            begin n_err++; $display("FAIL evict_replay: got ov=%b dout=%h want 1/66666666", is_output_valid, dout); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_cmp++; if (fetch_acc - acc0 !== 1) begin n_err++; $display("FAIL bp_one_fetch: got %0d want 1", fetch_acc - acc0); end
        n_cmp++; if (hit_count !== 32'd3 || miss_count !== 32'd2)
            begin n_err++; $display("FAIL evict_counts: got %0d/%0d want 3/2", hit_count, miss_count); end
    endtask

    task automatic test_reset_mid_miss();
        drive(1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300)
            begin n_err++; $display("FAIL rm_req: got v=%b a=%h want 1/00000300", mem_req_valid, mem_req_addr); end
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {4{32'hABCDABCD}};
        #1;
        n_cmp++; if (mem_req_valid !== 1'b0 || is_ready !== 1'b1)
            begin n_err++; $display("FAIL rm_idle: got v=%b rdy=%b want 0/1", mem_req_valid, is_ready); end
        n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
            begin n_err++; $display("FAIL rm_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
        tick();
        mem_resp_valid = 1'b0;
        drive(1'b1, 1'b0, 32'h300, 32'h0);
        #1;
        n_cmp++; if (is_hit !== 1'b0 || is_output_valid !== 1'b0)
            begin n_err++; $display("FAIL rm_remiss: got hit=%b ov=%b want 0/0", is_hit, is_output_valid); end
        drive(1'b1, 1'b0, 32'h204, 32'h0);
        #1;
        n_cmp++; if (is_hit !== 1'b0) begin n_err++; $display("FAIL rm_invalidated: got %b want 0", is_hit); end
        tick();
        n_cmp++; if (miss_count !== 32'd1 || mem_req_addr !== 32'h200)
            begin n_err++; $display("FAIL rm_new_miss: got cnt=%0d a=%h want 1/00000200", miss_count, mem_req_addr); end
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_store_load_hit();
        test_dirty_evict_backpressure();
        test_reset_mid_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_direct_mapped.md
# dcache_direct_mapped

Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's MEM stage and a multi-cycle backing memory. It replaces the single-cycle data memory path. Hits complete in the access cycle. On a miss the block deasserts `is_ready`, the CPU stalls its pipeline and holds the request, and the block writes back the dirty victim, fetches the line, and then replays the held access as a hit.

## Interface
- `LINE_BYTES`, default 16: line size in bytes. Power of two, at least 8.
- `NUM_SETS`, default 16: number of lines. Power of two.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high. Clock is `clk`.
- `is_input_valid` in 1: CPU access request.
- `addr` in 32: byte address, word-aligned (`addr[1:0]` ignored).
- `mem_rw` in 1: 1 = store, 0 = load.
- `din` in 32: store data.
- `is_ready` out 1: cache is in IDLE and can take a request.
- `is_output_valid` out 1: access completes this cycle.
- `dout` out 32: load data, valid with `is_output_valid`.
- `is_hit` out 1: tag match on a valid line for the current request.
- `mem_req_valid` out 1: backing memory request.
- `mem_req_write` out 1: 1 = line writeback, 0 = line fetch.
- `mem_req_addr` out 32: line-aligned address.
- `mem_req_wdata` out 8·LINE_BYTES: writeback data.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_resp_valid` in 1: one-cycle pulse carrying fetched line.
- `mem_resp_rdata` in 8·LINE_BYTES: fetched line.
- `hit_count` out 32: hits counted.
- `miss_count` out 32: misses counted.

## Operation
- Address fields:
  - offset = `addr[log2(LINE_BYTES)-1:0]`; word select = offset[.. :2].
  - index = next log2(NUM_SETS) bits.
  - tag = remaining upper bits.
- Per line: valid, dirty, tag, data.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE: `is_ready`=1.
  - If `is_input_valid` and hit:
    - `is_output_valid`=1.
    - Load: `dout` = selected word, combinational.
    - Store: word written at the clock edge and dirty set.
    - `hit_count`++ unless the replay flag is set; replay flag cleared.
  - If `is_input_valid` and miss:
    - `miss_count`++ and replay flag set.
    - Next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
- WRITEBACK: `mem_req_valid`=1, `mem_req_write`=1, `mem_req_addr`={victim tag, index, 0}, `mem_req_wdata`=victim line.
  - On `mem_req_ready`: victim dirty cleared, go to ALLOCATE.
- ALLOCATE: `mem_req_valid`=1, `mem_req_write`=0, `mem_req_addr`={request tag, index, 0}, held until `mem_req_ready`.
  - Then wait for `mem_resp_valid`.
  - On `mem_resp_valid`: line written with valid=1, dirty=0, new tag; go to IDLE.
- The replayed access is a hit and is not counted as a hit.
- `mem_req_*` stay stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- `is_input_valid` outside IDLE is ignored. The CPU must hold `addr`, `mem_rw` and `din` until `is_output_valid`.
- `mem_resp_valid` outside the ALLOCATE wait is ignored.
- `mem_req_ready` and `mem_resp_valid` may assert in the same cycle in ALLOCATE. The request counts as accepted and the fill happens.
- Counters wrap modulo 2^32.

## Timing
- Reset (clk edge with `reset`=1):
  - State = IDLE; all valid and dirty bits cleared; counters = 0; replay flag = 0.
  - Following cycle outputs: `is_ready`=1, `is_output_valid`=0, `is_hit`=0, `mem_req_valid`=0, `dout`=0.
- Reset mid-miss: the transaction is abandoned, `mem_req_valid`=0 from the next cycle, and a late `mem_resp_valid` is ignored.
- Hit latency: 0 cycles; response in the same cycle as the request.
- Clean miss: IDLE → ALLOCATE (1 cycle) → wait for memory → fill edge → IDLE → replay hit. That is 3 cycles plus memory latency.
- Dirty miss: adds the WRITEBACK cycles until `mem_req_ready`.
- Store hit data is visible to a load in the next cycle.

## Structure
- Package `dcache_pkg`:
  - state enum {IDLE, WRITEBACK, ALLOCATE}.
  - localparams for offset, index and tag widths derived from the parameters.
  - Field-extract functions.
- Sub-module `dcache_array`: tag/valid/dirty/data storage.
  - Asynchronous read by index.
  - Synchronous write ports for word store, line fill, and dirty clear.
  - Reset clears valid and dirty.
- Top level holds the FSM, counters, replay flag, hit compare, and memory request mux.

## Test plan
- Read miss: after reset, load `addr`=0x100, memory returns a line whose word 0 is 0xDEADBEEF.
  - One fetch request at 0x100.
  - `dout`=0xDEADBEEF on replay.
  - `miss_count`=1, `hit_count`=0.
- Store-then-load hit: store 0x12345678 to 0x104 (line resident), then load 0x104.
  - Both complete in 0 cycles.
  - Load returns 0x12345678.
  - `hit_count`=2.
- Dirty eviction: with 0x104 dirty, load 0x204 (same index 0, different tag).
  - WRITEBACK at 0x100 with word 1 = 0x12345678.
  - Then fetch at 0x200.
  - `miss_count`++.
- Backpressure: hold `mem_req_ready`=0 for 5 cycles in ALLOCATE.
  - `mem_req_*` stable throughout.
  - `is_ready`=0 throughout.
  - Exactly one request accepted.
- Reset mid-miss: assert `reset` while in ALLOCATE, then pulse `mem_resp_valid`.
  - State IDLE; no line becomes valid.
  - Counters = 0.
  - A load of the same address misses again.
